// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: single-port frame-buffer arbiter. Scanout reads always win; CPU writes queue in a small FIFO.
// Latency: video address -> oMemAddr 1 cycle, -> oPixel 2 cycles; CPU write -> memory at least 2 cycles.
// Backpressure: oWrReady drops while DEPTH writes are buffered; queued writes drain only during blanking.
module vga_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iDisplayActive,
  input  logic [ADDR_W-1:0]        iVideoAddr,
  input  logic                     iWrReq,
  input  logic [ADDR_W-1:0]        iWrAddr,
  input  logic [DATA_W-1:0]        iWrData,
  output logic                     oWrReady,
  output logic [ADDR_W-1:0]        oMemAddr,
  output logic [DATA_W-1:0]        oMemData,
  output logic                     oMemWe,
  input  logic [DATA_W-1:0]        iMemRdData,
  output logic [DATA_W-1:0]        oPixel,
  output logic                     oPixelValid,
  output logic [$clog2(DEPTH):0]   oPending
);

  // DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VIDEO = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_wr_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_video;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_we;
  logic              r_video_acc;
  logic              r_pix_vld;

  assign w_wr_ready  = (r_count < CNT_W'(DEPTH));
  assign w_push      = iWrReq && w_wr_ready;

  assign oWrReady    = w_wr_ready;
  assign oPending    = r_count;
  assign oMemAddr    = r_mem_addr;
  assign oMemData    = r_mem_data;
  assign oMemWe      = r_mem_we;
  assign oPixel      = iMemRdData;
  assign oPixelValid = r_pix_vld;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and access selection. Video takes the memory the moment iDisplayActive is seen;
  // a drain write is issued only once the machine is already in DRAIN, so a write landing in an
  // empty FIFO always spends one full cycle buffered before it is popped.
  always_comb begin
    w_next  = r_state;
    w_video = 1'b0;
    w_pop   = 1'b0;
    if (iDisplayActive) begin
      w_next = ST_VIDEO;
    end else if (r_count != '0) begin
      w_next = ST_DRAIN;
    end else begin
      w_next = ST_IDLE;
    end
    w_video = (w_next == ST_VIDEO);
    // next==DRAIN implies a non-empty FIFO, so the pop can never underflow.
    w_pop   = (w_next == ST_DRAIN) && (r_state == ST_DRAIN);
  end

  // FIFO storage; data slots need no reset because the pointers and count define validity.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= iWrAddr;
      r_fifo_data[r_wr_ptr] <= iWrData;
    end
  end

  // FIFO pointers and occupancy; a push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory port: one registered access per cycle; address/data hold when idle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
    end else if (w_video) begin
      r_mem_addr <= iVideoAddr;
      r_mem_we   <= 1'b0;
    end else if (w_pop) begin
      r_mem_addr <= r_fifo_addr[r_rd_ptr];
      r_mem_data <= r_fifo_data[r_rd_ptr];
      r_mem_we   <= 1'b1;
    end else begin
      r_mem_we   <= 1'b0;
    end
  end

  // Pixel valid tracks a video read one cycle later, matching the RAM read latency.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_video_acc <= 1'b0;
      r_pix_vld   <= 1'b0;
    end else begin
      r_video_acc <= w_video;
      r_pix_vld   <= r_video_acc;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed scenarios for the frame-buffer arbiter.
// The RAM is modelled as a registered read returning addr[7:0] ^ 8'hC3.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_vga_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iDisplayActive = 1'b0;
  logic [15:0] iVideoAddr = 16'h0000;
  logic        iWrReq = 1'b0;
  logic [15:0] iWrAddr = 16'h0000;
  logic [7:0]  iWrData = 8'h00;
  logic        oWrReady;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWe;
  logic [7:0]  iMemRdData = 8'h00;
  logic [7:0]  oPixel;
  logic        oPixelValid;
  logic [2:0]  oPending;

  int checks = 0;
  int errors = 0;

  vga_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DEPTH(4)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iDisplayActive (iDisplayActive),
    .iVideoAddr     (iVideoAddr),
    .iWrReq         (iWrReq),
    .iWrAddr        (iWrAddr),
    .iWrData        (iWrData),
    .oWrReady       (oWrReady),
    .oMemAddr       (oMemAddr),
    .oMemData       (oMemData),
    .oMemWe         (oMemWe),
    .iMemRdData     (iMemRdData),
    .oPixel         (oPixel),
    .oPixelValid    (oPixelValid),
    .oPending       (oPending)
  );

  always #5 Clock = ~Clock;

  // Synchronous RAM read model.
  always @(posedge Clock) iMemRdData <= oMemAddr[7:0] ^ 8'hC3;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL rst_we got %0h exp 0", oMemWe); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", oPending); end
    checks++; if (oWrReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", oWrReady); end
    checks++; if (oPixelValid !== 1'b0) begin errors++; $display("FAIL rst_pixvld got %0h exp 0", oPixelValid); end
    checks++; if (oMemAddr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", oMemAddr); end
    checks++; if (oMemData !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", oMemData); end
  endtask

  task automatic test_video();
    iDisplayActive = 1'b1;
    iVideoAddr = 16'h0010;
    Reset = 1'b0;
    tick();
    checks++; if (oMemAddr !== 16'h0010) begin errors++; $display("FAIL vid_addr1 got %h exp 0010", oMemAddr); end
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL vid_we1 got %0h exp 0", oMemWe); end
    checks++; if (oPixelValid !== 1'b0) begin errors++; $display("FAIL vid_pv1 got %0h exp 0", oPixelValid); end
    iVideoAddr = 16'h0011;
    tick();
    checks++; if (oPixelValid !== 1'b1) begin errors++; $display("FAIL vid_pv2 got %0h exp 1", oPixelValid); end
    checks++; if (oPixel !== 8'hD3) begin errors++; $display("FAIL vid_pix2 got %h exp d3", oPixel); end
    checks++; if (oMemAddr !== 16'h0011) begin errors++; $display("FAIL vid_addr2 got %h exp 0011", oMemAddr); end
    tick();
    checks++; if (oPixel !== 8'hD2) begin errors++; $display("FAIL vid_pix3 got %h exp d2", oPixel); end
  endtask

  task automatic test_buffer_full();
    // Display is active: four writes fill the buffer, a fifth is refused.
    for (int i = 0; i < 4; i++) begin
      iWrReq = 1'b1;
      iWrAddr = 16'h0100 + 16'(i);
      iWrData = 8'hA0 + 8'(i);
      tick();
    end
    iWrAddr = 16'h0104;
    iWrData = 8'hA4;
    checks++; if (oPending !== 3'd4) begin errors++; $display("FAIL full_pending got %0d exp 4", oPending); end
    checks++; if (oWrReady !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", oWrReady); end
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL full_we_video got %0h exp 0", oMemWe); end
    tick();
    iWrReq = 1'b0;
    checks++; if (oPending !== 3'd4) begin errors++; $display("FAIL full_ignored got %0d exp 4", oPending); end
    // Blanking: one cycle to enter DRAIN, then four back-to-back writes in order.
    iDisplayActive = 1'b0;
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL full_enter_we got %0h exp 0", oMemWe); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL full_dr%0d_we got %0h exp 1", i, oMemWe); end
      checks++; if (oMemAddr !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL full_dr%0d_addr got %h exp %h", i, oMemAddr, 16'h0100 + 16'(i)); end
      checks++; if (oMemData !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_dr%0d_data got %h exp %h", i, oMemData, 8'hA0 + 8'(i)); end
      checks++; if (oPending !== 3'(3 - i)) begin errors++; $display("FAIL full_dr%0d_pending got %0d exp %0d", i, oPending, 3 - i); end
      if (i == 0) begin
        checks++; if (oPixelValid !== 1'b0) begin errors++; $display("FAIL full_pv_blank got %0h exp 0", oPixelValid); end
      end
    end
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL full_idle_we got %0h exp 0", oMemWe); end
    checks++; if (oMemAddr !== 16'h0103) begin errors++; $display("FAIL full_idle_hold got %h exp 0103", oMemAddr); end
    checks++; if (oWrReady !== 1'b1) begin errors++; $display("FAIL full_idle_ready got %0h exp 1", oWrReady); end
  endtask

  task automatic test_single_write();
    iWrReq = 1'b1;
    iWrAddr = 16'h0200;
    iWrData = 8'h55;
    tick();
    iWrReq = 1'b0;
    checks++; if (oPending !== 3'd1) begin errors++; $display("FAIL sw_pending got %0d exp 1", oPending); end
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL sw_we0 got %0h exp 0", oMemWe); end
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL sw_we1 got %0h exp 0", oMemWe); end
    tick();
    checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL sw_we2 got %0h exp 1", oMemWe); end
    checks++; if (oMemAddr !== 16'h0200) begin errors++; $display("FAIL sw_addr got %h exp 0200", oMemAddr); end
    checks++; if (oMemData !== 8'h55) begin errors++; $display("FAIL sw_data got %h exp 55", oMemData); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL sw_pending2 got %0d exp 0", oPending); end
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL sw_we3 got %0h exp 0", oMemWe); end
  endtask

  task automatic test_interrupt();
    iDisplayActive = 1'b1;
    iVideoAddr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      iWrReq = 1'b1;
      iWrAddr = 16'h0300 + 16'(i);
      iWrData = 8'h30 + 8'(i);
      tick();
    end
    iWrReq = 1'b0;
    iDisplayActive = 1'b0;
    tick();
    tick();
    checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL int_pop_we got %0h exp 1", oMemWe); end
    checks++; if (oMemAddr !== 16'h0300) begin errors++; $display("FAIL int_pop_addr got %h exp 0300", oMemAddr); end
    checks++; if (oPending !== 3'd2) begin errors++; $display("FAIL int_pop_pending got %0d exp 2", oPending); end
    // Display comes back mid-burst: the next access must be a video read.
    iDisplayActive = 1'b1;
    iVideoAddr = 16'h0040;
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL int_vid_we got %0h exp 0", oMemWe); end
    checks++; if (oMemAddr !== 16'h0040) begin errors++; $display("FAIL int_vid_addr got %h exp 0040", oMemAddr); end
    checks++; if (oPending !== 3'd2) begin errors++; $display("FAIL int_vid_pending got %0d exp 2", oPending); end
    tick();
    checks++; if (oPixelValid !== 1'b1) begin errors++; $display("FAIL int_vid_pv got %0h exp 1", oPixelValid); end
    checks++; if (oPixel !== 8'h83) begin errors++; $display("FAIL int_vid_pix got %h exp 83", oPixel); end
    // Next blanking resumes the two retained entries.
    iDisplayActive = 1'b0;
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL int_enter_we got %0h exp 0", oMemWe); end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL int_res%0d_we got %0h exp 1", i, oMemWe); end
      checks++; if (oMemAddr !== 16'h0300 + 16'(i)) begin errors++; $display("FAIL int_res%0d_addr got %h exp %h", i, oMemAddr, 16'h0300 + 16'(i)); end
      checks++; if (oMemData !== 8'h30 + 8'(i)) begin errors++; $display("FAIL int_res%0d_data got %h exp %h", i, oMemData, 8'h30 + 8'(i)); end
    end
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL int_done_we got %0h exp 0", oMemWe); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL int_done_pending got %0d exp 0", oPending); end
  endtask

  task automatic test_back_to_back();
    // Fill during video, then hold iWrReq through blanking. Ready follows the count
    // combinationally, so the full count drops by one at the first pop and push/pop then balance.
    iDisplayActive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iWrReq = 1'b1;
      iWrAddr = 16'h0400 + 16'(i);
      iWrData = 8'h40 + 8'(i);
      tick();
    end
    iWrAddr = 16'h0404;
    iWrData = 8'h44;
    iDisplayActive = 1'b0;
    tick();
    checks++; if (oPending !== 3'd4) begin errors++; $display("FAIL b2b_enter_pending got %0d exp 4", oPending); end
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL b2b_enter_we got %0h exp 0", oMemWe); end
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL b2b_%0d_we got %0h exp 1", k, oMemWe); end
      checks++; if (oMemAddr !== 16'h0400 + 16'(k)) begin errors++; $display("FAIL b2b_%0d_addr got %h exp %h", k, oMemAddr, 16'h0400 + 16'(k)); end
      checks++; if (oMemData !== 8'h40 + 8'(k)) begin errors++; $display("FAIL b2b_%0d_data got %h exp %h", k, oMemData, 8'h40 + 8'(k)); end
      checks++; if (oPending !== 3'((k <= 5) ? 3 : (8 - k))) begin errors++; $display("FAIL b2b_%0d_pending got %0d exp %0d", k, oPending, (k <= 5) ? 3 : (8 - k)); end
      if (k < 5) begin
        iWrAddr = 16'h0404 + 16'(k);
        iWrData = 8'h44 + 8'(k);
      end else begin
        iWrReq = 1'b0;
      end
    end
    tick();
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL b2b_done_we got %0h exp 0", oMemWe); end
  endtask

  task automatic test_reset_mid_drain();
    int stale;
    iDisplayActive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iWrReq = 1'b1;
      iWrAddr = 16'h0500 + 16'(i);
      iWrData = 8'h50 + 8'(i);
      tick();
    end
    iWrReq = 1'b0;
    iDisplayActive = 1'b0;
    tick();
    tick();
    checks++; if (oMemWe !== 1'b1) begin errors++; $display("FAIL rmd_pop_we got %0h exp 1", oMemWe); end
    // Assert reset between edges and look before the next edge arrives.
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (oMemWe !== 1'b0) begin errors++; $display("FAIL rmd_async_we got %0h exp 0", oMemWe); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL rmd_async_pending got %0d exp 0", oPending); end
    checks++; if (oWrReady !== 1'b1) begin errors++; $display("FAIL rmd_async_ready got %0h exp 1", oWrReady); end
    checks++; if (oMemAddr !== 16'h0000) begin errors++; $display("FAIL rmd_async_addr got %h exp 0000", oMemAddr); end
    tick();
    Reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oMemWe !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rmd_stale_writes got %0d exp 0", stale); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL rmd_pending got %0d exp 0", oPending); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_buffer_full();
    test_single_write();
    test_interrupt();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
